// File: rtl/jts16_map_slot.sv
// jts16_map_slot: one-entry map word cache with hit compare, fill write and CPU-write snoop merge
module jts16_map_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] addr,
    input  logic        fill,
    input  logic        kill,
    input  logic [14:0] fill_addr,
    input  logic [15:0] fill_data,
    input  logic        vram_we,
    input  logic [14:0] vram_addr,
    input  logic [15:0] vram_dout,
    input  logic [1:0]  vram_dsn,
    output logic [15:0] data,
    output logic        ok
);
    logic [14:0] tag;
    logic        vld;
    logic        snoop;

    assign ok    = vld && tag == addr;
    assign snoop = vram_we && vld && tag == vram_addr;

    // a killed fill invalidates, a fill overwrites, otherwise a CPU write is merged byte by byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag  <= 15'd0;
            data <= 16'd0;
            vld  <= 1'b0;
        end else if (kill) begin
            vld <= 1'b0;
        end else if (fill) begin
            tag  <= fill_addr;
            data <= fill_data;
            vld  <= 1'b1;
        end else if (snoop) begin
            data <= {vram_dsn[1] ? data[15:8] : vram_dout[15:8],
                     vram_dsn[0] ? data[7:0]  : vram_dout[7:0]};
        end
    end
endmodule

// File: rtl/jts16_map_arb.sv
// jts16_map_arb: merges two cached tile-map fetch ports onto one SDRAM read slot
module jts16_map_arb #(
    parameter logic [21:0] BASE = 22'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        map1_cs,
    input  logic [14:0] map1_addr,
    output logic [15:0] map1_data,
    output logic        map1_ok,
    input  logic        map2_cs,
    input  logic [14:0] map2_addr,
    output logic [15:0] map2_data,
    output logic        map2_ok,
    input  logic        vram_we,
    input  logic [14:0] vram_addr,
    input  logic [15:0] vram_dout,
    input  logic [1:0]  vram_dsn,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_din
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic        owner;
    logic        last;
    logic        stale;
    logic [14:0] req_addr;
    logic        miss1, miss2, both, gnt, hit_req, fill, fill_ok;

    assign miss1   = map1_cs && !map1_ok;
    assign miss2   = map2_cs && !map2_ok;
    assign both    = miss1 && miss2;
    assign gnt     = both ? !last : miss2;
    assign hit_req = vram_we && vram_addr == req_addr;
    assign fill    = state == BUSY && sdram_rdy;
    assign fill_ok = fill && !stale && !hit_req;

    // grant a missing port, hold the request until rdy; last only tracks contended grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            stale      <= 1'b0;
            req_addr   <= 15'd0;
            sdram_req  <= 1'b0;
            sdram_addr <= 22'd0;
        end else if (state == IDLE) begin
            if (miss1 || miss2) begin
                state      <= BUSY;
                owner      <= gnt;
                last       <= both ? gnt : last;
                stale      <= 1'b0;
                req_addr   <= gnt ? map2_addr : map1_addr;
                sdram_addr <= BASE + {7'd0, gnt ? map2_addr : map1_addr};
                sdram_req  <= 1'b1;
            end
        end else begin
            stale <= stale || hit_req;
            if (sdram_rdy) begin
                state     <= IDLE;
                sdram_req <= 1'b0;
            end
        end
    end

    jts16_map_slot u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (map1_addr),
        .fill      (fill_ok && !owner),
        .kill      (fill && hit_req && !owner),
        .fill_addr (req_addr),
        .fill_data (sdram_din),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .vram_dsn  (vram_dsn),
        .data      (map1_data),
        .ok        (map1_ok)
    );

    jts16_map_slot u_slot2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (map2_addr),
        .fill      (fill_ok && owner),
        .kill      (fill && hit_req && owner),
        .fill_addr (req_addr),
        .fill_data (sdram_din),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .vram_dsn  (vram_dsn),
        .data      (map2_data),
        .ok        (map2_ok)
    );
endmodule

// File: tb/tb_jts16_map_arb.sv
// tb_jts16_map_arb: table vectors, directed corner sequences and a random run against a behavioural model
module tb_jts16_map_arb;
    localparam logic [21:0] BASE   = 22'h10000;
    localparam logic [21:0] BASE_W = 22'h3FFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c1, c2, rdy, we;
    logic [14:0] a1, a2, wa;
    logic [15:0] din, wd;
    logic [1:0]  dsn;

    logic [15:0] map1_data, map2_data, w_map1_data, w_map2_data;
    logic        map1_ok, map2_ok, w_map1_ok, w_map2_ok;
    logic        sdram_req, w_sdram_req;
    logic [21:0] sdram_addr, w_sdram_addr;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    jts16_map_arb #(.BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .map1_cs(c1), .map1_addr(a1), .map1_data(map1_data), .map1_ok(map1_ok),
        .map2_cs(c2), .map2_addr(a2), .map2_data(map2_data), .map2_ok(map2_ok),
        .vram_we(we), .vram_addr(wa), .vram_dout(wd), .vram_dsn(dsn),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_rdy(rdy), .sdram_din(din)
    );

    jts16_map_arb #(.BASE(BASE_W)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .map1_cs(c1), .map1_addr(a1), .map1_data(w_map1_data), .map1_ok(w_map1_ok),
        .map2_cs(c2), .map2_addr(a2), .map2_data(w_map2_data), .map2_ok(w_map2_ok),
        .vram_we(we), .vram_addr(wa), .vram_dout(wd), .vram_dsn(dsn),
        .sdram_req(w_sdram_req), .sdram_addr(w_sdram_addr), .sdram_rdy(rdy), .sdram_din(din)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic c1; logic [14:0] a1; logic c2; logic [14:0] a2;
        logic rdy; logic [15:0] din; logic we; logic [14:0] wa; logic [15:0] wd; logic [1:0] dsn;
        logic req; logic [21:0] sa; logic ok1; logic [15:0] d1; logic ok2; logic [15:0] d2;
    } vec_t;

    function automatic vec_t row(int c1_, int a1_, int c2_, int a2_, int rdy_, int din_, int we_,
                                 int wa_, int wd_, int dsn_, int req_, int sa_, int ok1_, int d1_,
                                 int ok2_, int d2_);
        vec_t r;
        r.c1 = 1'(c1_);   r.a1 = 15'(a1_);  r.c2 = 1'(c2_);  r.a2 = 15'(a2_);
        r.rdy = 1'(rdy_); r.din = 16'(din_); r.we = 1'(we_); r.wa = 15'(wa_);
        r.wd = 16'(wd_);  r.dsn = 2'(dsn_); r.req = 1'(req_); r.sa = 22'(sa_);
        r.ok1 = 1'(ok1_); r.d1 = 16'(d1_);  r.ok2 = 1'(ok2_); r.d2 = 16'(d2_);
        return r;
    endfunction

    // behavioural reference: two cached words, one outstanding read, contended-grant history
    logic        m_vld[2];
    logic [14:0] m_tag[2];
    logic [15:0] m_dat[2];
    bit          m_busy, m_stale;
    int          m_who, m_last;
    logic [14:0] m_addr;
    logic [21:0] m_sa, m_wsa;

    function automatic void m_reset();
        for (int n = 0; n < 2; n++) begin
            m_vld[n] = 1'b0; m_tag[n] = 15'd0; m_dat[n] = 16'd0;
        end
        m_busy = 0; m_stale = 0; m_who = 0; m_last = 1;
        m_addr = 15'd0; m_sa = 22'd0; m_wsa = 22'd0;
    endfunction

    task automatic model_check();
        logic [14:0] a[2];
        logic        c[2], ok[2], miss[2];
        bit          same;
        int          g;
        a[0] = a1; a[1] = a2; c[0] = c1; c[1] = c2;
        if (!rst_n) m_reset();
        for (int n = 0; n < 2; n++) ok[n] = m_vld[n] && m_tag[n] == a[n];
        cmp("ok1", 32'(map1_ok), 32'(ok[0]));
        cmp("ok2", 32'(map2_ok), 32'(ok[1]));
        cmp("data1", 32'(map1_data), 32'(m_dat[0]));
        cmp("data2", 32'(map2_data), 32'(m_dat[1]));
        cmp("req", 32'(sdram_req), 32'(m_busy));
        cmp("addr", 32'(sdram_addr), 32'(m_sa));
        cmp("w_addr", 32'(w_sdram_addr), 32'(m_wsa));
        cmp("w_req", 32'(w_sdram_req), 32'(m_busy));
        cmp("w_ok", 32'({w_map1_ok, w_map2_ok}), 32'({ok[0], ok[1]}));
        cmp("w_data", 32'({w_map1_data, w_map2_data}), {m_dat[0], m_dat[1]});
        if (!rst_n) return;
        for (int n = 0; n < 2; n++) begin
            miss[n] = c[n] && !ok[n];
            if (we && m_vld[n] && m_tag[n] == wa) begin
                if (!dsn[1]) m_dat[n][15:8] = wd[15:8];
                if (!dsn[0]) m_dat[n][7:0]  = wd[7:0];
            end
        end
        if (!m_busy) begin
            if (miss[0] || miss[1]) begin
                g = (miss[0] && miss[1]) ? 1 - m_last : (miss[0] ? 0 : 1);
                if (miss[0] && miss[1]) m_last = g;
                m_busy = 1; m_stale = 0; m_who = g; m_addr = a[g];
                m_sa  = 22'((int'(BASE)   + int'(a[g])) % 4194304);
                m_wsa = 22'((int'(BASE_W) + int'(a[g])) % 4194304);
            end
        end else begin
            same = we && wa == m_addr;
            if (rdy) begin
                m_busy = 0;
                if (same) m_vld[m_who] = 1'b0;
                else if (!m_stale) begin
                    m_vld[m_who] = 1'b1; m_tag[m_who] = m_addr; m_dat[m_who] = din;
                end
            end else if (same) m_stale = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        if (sdram_req && !prev_req && sdram_addr == 22'h10050) rises++;
        prev_req = sdram_req;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        we  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c1 = 0; c2 = 0; a1 = 0; a2 = 0; rdy = 0; din = 0; we = 0; wa = 0; wd = 0; dsn = 2'b11;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t        tbl[23];
    logic [14:0] pool[4] = '{15'h0, 15'h1, 15'h2, 15'h7FFF};

    initial begin
        rst_n = 1'b0;
        c1 = 0; c2 = 0; a1 = 0; a2 = 0; rdy = 0; din = 0; we = 0; wa = 0; wd = 0; dsn = 2'b11;
        //            c1 a1     c2 a2     rdy din      we wa     wd       dsn req sa        ok1 d1       ok2 d2
        tbl[0]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  0, 0,        0, 0,        0, 0);
        tbl[1]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  1, 'h10123,  0, 0,        0, 0);
        tbl[2]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  1, 'h10123,  0, 0,        0, 0);
        tbl[3]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  1, 'h10123,  0, 0,        0, 0);
        tbl[4]  = row(1, 'h123, 0, 0,     1, 'hBEEF,   0, 0,     0,       3,  1, 'h10123,  0, 0,        0, 0);
        tbl[5]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  0, 'h10123,  1, 'hBEEF,   0, 0);
        tbl[6]  = row(1, 'h123, 0, 0,     0, 0,        0, 0,     0,       3,  0, 'h10123,  1, 'hBEEF,   0, 0);
        tbl[7]  = row(1, 'h10,  1, 'h20,  0, 0,        0, 0,     0,       3,  0, 'h10123,  0, 'hBEEF,   0, 0);
        tbl[8]  = row(1, 'h10,  1, 'h20,  0, 0,        0, 0,     0,       3,  1, 'h10010,  0, 'hBEEF,   0, 0);
        tbl[9]  = row(1, 'h10,  1, 'h20,  1, 'h1111,   0, 0,     0,       3,  1, 'h10010,  0, 'hBEEF,   0, 0);
        tbl[10] = row(1, 'h10,  1, 'h20,  0, 0,        0, 0,     0,       3,  0, 'h10010,  1, 'h1111,   0, 0);
        tbl[11] = row(1, 'h10,  1, 'h20,  1, 'h2222,   0, 0,     0,       3,  1, 'h10020,  1, 'h1111,   0, 0);
        tbl[12] = row(1, 'h11,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10020,  0, 'h1111,   0, 'h2222);
        tbl[13] = row(1, 'h11,  1, 'h21,  1, 'h3333,   0, 0,     0,       3,  1, 'h10021,  0, 'h1111,   0, 'h2222);
        tbl[14] = row(1, 'h11,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10021,  0, 'h1111,   1, 'h3333);
        tbl[15] = row(1, 'h11,  1, 'h21,  1, 'h4444,   0, 0,     0,       3,  1, 'h10011,  0, 'h1111,   1, 'h3333);
        tbl[16] = row(1, 'h11,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10011,  1, 'h4444,   1, 'h3333);
        tbl[17] = row(1, 'h40,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10011,  0, 'h4444,   1, 'h3333);
        tbl[18] = row(1, 'h40,  1, 'h21,  1, 'h1234,   0, 0,     0,       3,  1, 'h10040,  0, 'h4444,   1, 'h3333);
        tbl[19] = row(1, 'h40,  1, 'h21,  0, 0,        1, 'h40,  'hABCD,  1,  0, 'h10040,  1, 'h1234,   1, 'h3333);
        tbl[20] = row(1, 'h40,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10040,  1, 'hAB34,   1, 'h3333);
        tbl[21] = row(1, 'h40,  1, 'h21,  0, 0,        1, 'h21,  'h5566,  2,  0, 'h10040,  1, 'hAB34,   1, 'h3333);
        tbl[22] = row(1, 'h40,  1, 'h21,  0, 0,        0, 0,     0,       3,  0, 'h10040,  1, 'hAB34,   1, 'h3366);

        repeat (2) @(posedge clk);
        #1;
        cmp("reset_req", 32'(sdram_req), 32'd0);
        cmp("reset_addr", 32'(sdram_addr), 32'd0);
        cmp("reset_ok", 32'({map1_ok, map2_ok}), 32'd0);
        cmp("reset_data", {map1_data, map2_data}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            logic [21:0] ew;
            c1 = tbl[i].c1; a1 = tbl[i].a1; c2 = tbl[i].c2; a2 = tbl[i].a2;
            rdy = tbl[i].rdy; din = tbl[i].din; we = tbl[i].we; wa = tbl[i].wa;
            wd = tbl[i].wd; dsn = tbl[i].dsn;
            ew = tbl[i].sa == 22'd0 ? 22'd0
               : 22'((int'(tbl[i].sa) - int'(BASE) + int'(BASE_W)) % 4194304);
            @(negedge clk);
            cmp($sformatf("row%0d_req", i), 32'(sdram_req), 32'(tbl[i].req));
            cmp($sformatf("row%0d_addr", i), 32'(sdram_addr), 32'(tbl[i].sa));
            cmp($sformatf("row%0d_waddr", i), 32'(w_sdram_addr), 32'(ew));
            cmp($sformatf("row%0d_ok1", i), 32'(map1_ok), 32'(tbl[i].ok1));
            cmp($sformatf("row%0d_d1", i), 32'(map1_data), 32'(tbl[i].d1));
            cmp($sformatf("row%0d_ok2", i), 32'(map2_ok), 32'(tbl[i].ok2));
            cmp($sformatf("row%0d_d2", i), 32'(map2_data), 32'(tbl[i].d2));
            @(posedge clk);
            #1;
        end

        // snoop on the in-flight address makes the fill stale and forces a second read
        do_reset();
        rises = 0;
        c1 = 1; a1 = 15'h50; tick();
        we = 1; wa = 15'h50; wd = 16'h9999; dsn = 2'b00; tick();
        rdy = 1; din = 16'hAAAA; tick();
        tick();
        rdy = 1; din = 16'hBBBB; tick();
        tick();
        cmp("stale_rereq_count", 32'(rises), 32'd2);
        cmp("stale_final_data", 32'(map1_data), 32'hBBBB);
        cmp("stale_final_ok", 32'(map1_ok), 32'd1);
        // snoop and fill in the same cycle at the same address clears the entry
        a1 = 15'h52; tick();
        rdy = 1; din = 16'hCCCC; we = 1; wa = 15'h52; wd = 16'h0101; dsn = 2'b00; tick();
        cmp("kill_ok", 32'(map1_ok), 32'd0);
        tick();
        rdy = 1; din = 16'hDDDD; tick();
        tick();
        cmp("kill_refetch_data", 32'(map1_data), 32'hDDDD);

        // requester moves its address while its read is in flight
        do_reset();
        c2 = 1; a2 = 15'h60; tick();
        a2 = 15'h61; tick();
        rdy = 1; din = 16'h6060; tick();
        cmp("move_ok_low", 32'(map2_ok), 32'd0);
        a2 = 15'h60;
        #1;
        cmp("move_old_tag_hit", 32'(map2_ok), 32'd1);
        tick();
        a2 = 15'h61; tick();
        cmp("move_refetch_req", 32'(sdram_req), 32'd1);
        cmp("move_refetch_addr", 32'(sdram_addr), 32'h10061);
        rdy = 1; din = 16'h6161; tick();
        tick();
        cmp("move_refetch_data", 32'(map2_data), 32'h6161);

        // reset in the middle of a read, then a stray rdy
        do_reset();
        c1 = 1; a1 = 15'h70; tick();
        tick();
        rst_n = 1'b0; tick();
        cmp("midrst_req", 32'(sdram_req), 32'd0);
        cmp("midrst_addr", 32'(sdram_addr), 32'd0);
        rst_n = 1'b1; c1 = 0; rdy = 1; din = 16'hDEAD; tick();
        cmp("stray_ok", 32'(map1_ok), 32'd0);
        cmp("stray_data", 32'(map1_data), 32'd0);
        cmp("stray_req", 32'(sdram_req), 32'd0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom % 400) != 0;
            c1  = ($urandom % 5) != 0;
            c2  = ($urandom % 5) != 0;
            a1  = pool[$urandom % 4];
            a2  = pool[$urandom % 4];
            rdy = ($urandom % 3) == 0;
            din = 16'($urandom);
            we  = ($urandom % 5) == 0;
            wa  = pool[$urandom % 4];
            wd  = 16'($urandom);
            dsn = 2'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jts16_map_arb.md
# jts16_map_arb

Arbiter with a one-entry cache per requester. It merges the two tile-map fetch ports (map1, map2) of the S16 scroll layers onto a single SDRAM read slot. Both ports read the same map VRAM image in SDRAM. Each port holds its last fetched word, so a scroll layer that re-reads an unchanged address gets `ok` without an SDRAM access. A CPU-write snoop keeps both cached words coherent with tile RAM. The block sits between the two scroll layers of the S16 video stage and the SDRAM bank controller.

## Interface
Parameters:
- `BASE`, 22'h0, word offset of the map VRAM image in SDRAM; added to every request.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `map1_cs` in 1: port 1 read enable.
- `map1_addr` in 15: port 1 word address.
- `map1_data` out 16: port 1 cached word.
- `map1_ok` out 1: `map1_data` is valid for the current `map1_addr`.
- `map2_cs`, `map2_addr`, `map2_data`, `map2_ok`: same as port 1, for port 2.
- `vram_we` in 1: CPU write strobe to tile RAM, one cycle.
- `vram_addr` in 15: word address of the CPU write.
- `vram_dout` in 16: CPU write data.
- `vram_dsn` in 2: byte strobes, active-low; bit 1 is the upper byte.
- `sdram_req` out 1: read request.
- `sdram_addr` out 22: request address, `BASE` + client address, modulo 2^22.
- `sdram_rdy` in 1: one-cycle pulse; `sdram_din` is valid in that cycle.
- `sdram_din` in 16: read data.

## Operation
- Per-port state: `tag[14:0]`, `dat[15:0]`, `vld`.
- `mapN_ok` = `vld` && (`tag` == `mapN_addr`).
  - Combinational on the registered state.
  - Independent of `cs`.
  - Drops in the same cycle that the address changes.
- `mapN_data` = `dat`, registered.
- A port is in miss when `cs` && !`ok`.
- FSM states: IDLE, BUSY.
- IDLE behaviour:
  - If any port is in miss, grant one port and latch it as `owner`.
  - Latch `sdram_addr` = `BASE` + owner address.
  - Raise `sdram_req` and go to BUSY.
  - Round-robin: if both ports miss, grant the port that was not granted last. The first grant after reset goes to port 1.
- BUSY behaviour:
  - `sdram_req` stays high until `sdram_rdy`.
  - On `sdram_rdy`: drop `req`, go to IDLE, and write `tag`, `dat` and `vld` of the owner. Do not write the cache if the fill is marked stale (see the snoop rules).
- Requester address change during BUSY:
  - The fill still completes with the latched address.
  - The requester sees `ok`=0 because its address no longer matches the tag, and it re-misses.
- Snoop on `vram_we`, applied to each port with `vld` && `tag` == `vram_addr`:
  - Merge the write into `dat`: upper byte when `dsn[1]`=0, lower byte when `dsn[0]`=0.
  - `vld` is unchanged.
- Snoop during BUSY, when `vram_addr` == the latched request address:
  - Mark the fill stale.
  - The stale fill is discarded and the owner re-misses.
- Snoop and fill in the same cycle at the same address: the fill data is discarded and `vld` is cleared for the owner.
- `cs` low: the port never requests, but it still reports `ok` and still snoops.

## Timing
- Reset values:
  - `sdram_req`=0, `sdram_addr`=0.
  - `mapN_data`=0, `mapN_ok`=0 (all `vld`=0).
  - State IDLE; last grant = port 2.
- Hit: 0 cycles; `ok` is high in the cycle the address is presented.
- Miss:
  - The address is presented in cycle 0; `sdram_req` rises at edge 1.
  - `rdy` arrives in cycle N; `vld`, `tag` and `dat` update at edge N+1; `ok` is high from cycle N+1.
- Back-to-back misses: the next `req` can rise one cycle after `rdy`. The IDLE cycle is mandatory.
- Reset asserted mid-BUSY:
  - Immediate return to reset values.
  - A late `sdram_rdy` in IDLE is ignored.
- `sdram_rdy` in IDLE is always ignored.
- Address arithmetic wraps at 22 bits; no carry out.

## Structure
- No shared package is needed.
- Define the FSM state encoding as a localparam inside the module.
- One sub-module, `jts16_map_slot`. It holds `tag`, `dat` and `vld` and contains the hit compare, fill write and snoop merge. It is instantiated twice.
- The arbiter and FSM stay in the top module.
- Expected size: about 150–250 lines of RTL.

## Test plan
- Reset release, port 1 reads 0x0123, SDRAM returns 0xBEEF after 4 cycles, with `BASE`=0x10000:
  - `sdram_addr`=0x10123.
  - `map1_ok` is high 1 cycle after `rdy`, with data 0xBEEF.
  - A re-read issues no new `req`.
- Both ports miss in the same cycle (0x0010, 0x0020):
  - Port 1 is served first, then port 2.
  - The next simultaneous miss goes to port 2 first.
  - `req` is low for exactly one cycle between the two grants.
- Cached 0x0040 = 0x1234; CPU write of 0xABCD with `dsn`=2'b01:
  - `dat`=0xAB34.
  - `ok` stays high.
  - No SDRAM access.
- Snoop at 0x0050 while BUSY fetching 0x0050:
  - The fill is discarded and the port re-misses.
  - A second `req` to 0x0050 occurs.
  - The final data equals the second read.
- Port 2 changes address from 0x0060 to 0x0061 while BUSY:
  - The fill writes tag 0x0060.
  - `ok` stays low, then a fetch of 0x0061 follows.
- `rst_n` pulsed low mid-BUSY, followed by a stray `rdy`:
  - All outputs return to their reset values.
  - No `ok` is asserted and no cache write occurs.
